sim_console: RTL and testbench
==============================

Name: sim_console

Overview:
- Memory-mapped simulation console and exit device on the data-memory bus of the simulation top.
- Consumes core stores to its register window.
- Buffers output bytes in a FIFO and drains them to the Verilator host harness through a valid/ready byte stream.
- Latches the program exit code and raises halted, so the harness can end the run.

Parameters:
- XLEN, 32, data bus width in bits (matches `D_XLEN).
- DEPTH, 16, TX FIFO depth in bytes; power of two, 2..256.
- CYCLE_W, 64, width of the free-running cycle counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  bus request valid
- req_ready  out  1  bus request accepted this cycle when high with req_valid
- req_we  in  1  1=write, 0=read
- req_offset  in  4  byte offset within device window (already decoded upstream)
- req_wdata  in  XLEN  write data
- resp_valid  out  1  read response valid
- resp_rdata  out  XLEN  read response data
- tx_valid  out  1  FIFO head byte available to host
- tx_data  out  8  FIFO head byte
- tx_ready  in  1  host consumes head byte when high with tx_valid
- halted  out  1  program has written EXIT
- exit_code  out  XLEN  value written to EXIT

Behaviour:
- Reset (reset low, async): FIFO empty, count=0; cycle counter=0; halted=0; exit_code=0; resp_valid=0; resp_rdata=0; tx_valid=0.
- Register map, req_offset[3:2]:
  - 0 TXDATA: W pushes req_wdata[7:0]; R returns 0.
  - 1 STATUS: R returns bit0=full, bit1=empty, bit2=halted, bits[15:8]=count; W ignored.
  - 2 EXIT: W sets halted=1 and exit_code=req_wdata; R returns exit_code.
  - 3 CYCLE: R returns cycle[XLEN-1:0]; W ignored.
  - req_offset[1:0] ignored.
- req_ready is combinational: low only when req_valid and req_we and offset=TXDATA and FIFO full; high otherwise, including when full with a same-cycle pop. No bypass.
- Accepted reads: resp_valid=1 exactly one cycle later, with resp_rdata sampled at acceptance. Otherwise resp_valid=0 and resp_rdata holds its last value. Writes produce no response.
- FIFO:
  - Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
  - tx_valid = !empty; tx_data = mem[rd_ptr] (registered memory, combinational read).
  - Pop when tx_valid && tx_ready.
  - Simultaneous push and pop on a non-empty FIFO: count unchanged, both pointers advance.
  - Push to empty with no pop: tx_valid rises the next cycle.
- EXIT:
  - First accepted write sets halted; halted and exit_code are then sticky until reset. Later EXIT writes are ignored.
  - TXDATA pushes and host drains continue after halted, so trailing output is never lost.
- Cycle counter increments every cycle while halted=0 and freezes on the cycle halted rises. Wraps modulo 2^CYCLE_W.
- Reset asserted mid-transfer: all state is cleared immediately, in-flight bytes are discarded, and any pending resp_valid is dropped.
- No state machine beyond FIFO pointers and the halted flag. A one-deep response register gives the read latency.

Optional Feature:
- Macro: SIM_CONSOLE_DISPLAY_EN.
- Defined:
  - Each pop also executes $write("%c", tx_data) inside the block.
  - On the rising edge of halted, executes $display with exit_code, then $finish after the FIFO is empty.
  - tx_ready is still honoured.
- Undefined: no system tasks are compiled in; the block is fully synthesizable and the host harness owns printing and termination.

Test Plan:
- Reset release, no traffic -> tx_valid=0, halted=0, STATUS read returns 0x00000002 one cycle after acceptance; CYCLE read at cycle 10 after reset returns 10±1 (request-to-sample alignment).
- Write TXDATA 0x48, 0x69 with tx_ready=1 -> tx_data 0x48 then 0x69 on consecutive tx_valid cycles; FIFO empty afterwards.
- tx_ready=0, 16 TXDATA writes -> STATUS=0x00001001 (full, count 16); 17th write sees req_ready=0 until tx_ready pulses once, then it is accepted; drained order is preserved across pointer wrap.
- Push and pop in the same cycle with count=3 -> count stays 3; head advances by one byte.
- Write EXIT 0x0000002A, then EXIT 0x1 -> halted=1, exit_code=0x2A both times; CYCLE reads identical values 5 cycles apart; a later TXDATA 0x0A still drains.
- Reset pulsed low mid-drain with count=5 -> tx_valid=0 and count=0 immediately (asynchronous); halted=0, exit_code=0.

Source files
------------

// File: rtl/sim_console.sv
// ---------------------------------------------------------------------------
// sim_console
//
// Memory-mapped simulation console and exit device on the data-memory bus.
//
// Bytes written to TXDATA are queued in a small TX FIFO. The host harness
// drains that FIFO through a valid/ready byte stream. A write to EXIT latches
// the program exit code and raises halted, which the harness uses to end the
// run. A free-running cycle counter can be read back and freezes once halted.
//
// Register window (selected by req_offset[3:2]; req_offset[1:0] are ignored):
//   0 TXDATA  W: push req_wdata[7:0]        R: 0
//   1 STATUS  R: bit0 full, bit1 empty, bit2 halted, bits[15:8] count
//   2 EXIT    W: first write sets halted and exit_code   R: exit_code
//   3 CYCLE   R: cycle[XLEN-1:0]
//
// Ports:
//   clk, reset (asynchronous, active-low)
//   req_valid/req_ready/req_we/req_offset/req_wdata : bus request
//   resp_valid/resp_rdata                           : read response, 1 cycle after acceptance
//   tx_valid/tx_data/tx_ready                       : byte stream to the host
//   halted/exit_code                                : program termination status
//
// Build option:
//   SIM_CONSOLE_DISPLAY_EN - when defined, the block prints each drained byte
//   itself, reports the exit code when halted rises and ends the simulation
//   once the FIFO is empty. When undefined, no system tasks are compiled in.
// ---------------------------------------------------------------------------
module sim_console #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 16,
    parameter int CYCLE_W = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [3:0]      req_offset,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            tx_valid,
    output logic [7:0]      tx_data,
    input  logic            tx_ready,
    output logic            halted,
    output logic [XLEN-1:0] exit_code
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_EXIT   = 2'd2;
    localparam logic [1:0] REG_CYCLE  = 2'd3;

    // FIFO storage carries no reset: only the pointers and count define validity.
    logic [7:0]         mem_q [DEPTH];

    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [CYCLE_W-1:0] cycle_q, cycle_d;
    logic               halted_q, halted_d;
    logic [XLEN-1:0]    exit_code_q, exit_code_d;
    logic               resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]    resp_rdata_q, resp_rdata_d;

    logic [1:0]         sel;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               rd_acc;
    logic               exit_wr;
    logic [XLEN-1:0]    status;
    logic [XLEN-1:0]    rd_mux;

    // Byte-lane offset bits are decoded away upstream.
    logic               unused_offset_bits;
    assign unused_offset_bits = ^req_offset[1:0];

    assign sel   = req_offset[3:2];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign pop   = !empty && tx_ready;

    // A full FIFO still accepts a push when the host pops the head in the
    // same cycle; there is no empty-FIFO bypass to the stream.
    assign req_ready = !(req_valid && req_we && (sel == REG_TXDATA) && full && !pop);

    assign push    = req_valid && req_we && (sel == REG_TXDATA) && req_ready;
    assign rd_acc  = req_valid && !req_we;
    assign exit_wr = req_valid && req_we && (sel == REG_EXIT) && !halted_q;

    always_comb begin
        status        = '0;
        status[0]     = full;
        status[1]     = empty;
        status[2]     = halted_q;
        status[15:8]  = 8'(count_q);
    end

    always_comb begin
        rd_mux = '0;
        case (sel)
            REG_TXDATA: rd_mux = '0;
            REG_STATUS: rd_mux = status;
            REG_EXIT:   rd_mux = exit_code_q;
            REG_CYCLE:  rd_mux = XLEN'(cycle_q);
            default:    rd_mux = '0;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Halted and exit_code are sticky; later EXIT writes are dropped.
        halted_d    = halted_q | exit_wr;
        exit_code_d = exit_wr ? req_wdata : exit_code_q;

        // Counts the cycle on which halted rises, then freezes.
        cycle_d = halted_q ? cycle_q : cycle_q + 1'b1;

        // Read data is captured at acceptance and held until the next read.
        resp_valid_d = rd_acc;
        resp_rdata_d = rd_acc ? rd_mux : resp_rdata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            cycle_q      <= '0;
            halted_q     <= 1'b0;
            exit_code_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            cycle_q      <= cycle_d;
            halted_q     <= halted_d;
            exit_code_q  <= exit_code_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= req_wdata[7:0];
        end
    end

    assign tx_valid   = !empty;
    assign tx_data    = mem_q[rd_ptr_q];
    assign halted     = halted_q;
    assign exit_code  = exit_code_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;

`ifdef SIM_CONSOLE_DISPLAY_EN
    // Self-printing console: termination waits for trailing output to drain.
    logic finish_pending_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            finish_pending_q <= 1'b0;
        end else begin
            if (pop) begin
                $write("%c", tx_data);
            end
            if (halted_d && !halted_q) begin
                $display("sim_console: exit_code=0x%0h", exit_code_d);
                finish_pending_q <= 1'b1;
            end
            if (finish_pending_q && empty) begin
                $finish;
            end
        end
    end
`else
    // The host harness owns printing and end-of-run handling.
`endif

endmodule

// File: tb/tb_sim_console.sv
// ---------------------------------------------------------------------------
// tb_sim_console
//
// Directed bench for sim_console. A queue-based model of the console tracks
// the FIFO contents, halted/exit_code, the cycle count and the read response;
// a monitor compares the DUT against it on every falling clock edge, and the
// stimulus adds hand-computed literal expectations for each scenario.
// ---------------------------------------------------------------------------
module tb_sim_console;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_we = 1'b0;
    logic [3:0]      req_offset = 4'h0;
    logic [XLEN-1:0] req_wdata = '0;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            tx_valid;
    logic [7:0]      tx_data;
    logic            tx_ready = 1'b0;
    logic            halted;
    logic [XLEN-1:0] exit_code;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model state
    logic [7:0]      m_q[$];
    bit              m_halted = 1'b0;
    logic [31:0]     m_exit = '0;
    bit              m_resp_valid = 1'b0;
    logic [31:0]     m_resp_rdata = '0;
    longint unsigned m_cycle = 0;

    // Bytes seen leaving the stream (valid && ready)
    logic [7:0]      drained[$];

    sim_console #(.XLEN(XLEN), .DEPTH(DEPTH), .CYCLE_W(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_offset (req_offset),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .halted     (halted),
        .exit_code  (exit_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] sel);
        logic [31:0] v;
        case (sel)
            2'd0:    v = 32'h0;
            2'd1:    v = {16'h0, 8'(m_q.size()), 5'b0, m_halted,
                          (m_q.size() == 0), (m_q.size() == DEPTH)};
            2'd2:    v = m_exit;
            default: v = m_cycle[31:0];
        endcase
        return v;
    endfunction

    function automatic bit m_ready();
        bit pop_now;
        pop_now = (m_q.size() != 0) && tx_ready;
        return !(req_valid && req_we && (req_offset[3:2] == 2'd0)
                 && (m_q.size() == DEPTH) && !pop_now);
    endfunction

    function automatic logic [7:0] dq(input int i);
        if (i < drained.size()) return drained[i];
        return 8'hEE;
    endfunction

    // Model update: what the console must look like after each clock edge.
    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_q.delete();
                m_halted     = 1'b0;
                m_exit       = '0;
                m_resp_valid = 1'b0;
                m_resp_rdata = '0;
                m_cycle      = 0;
            end else begin
                bit was_halted;
                bit pop_now;
                bit push_now;
                logic [31:0] rd_val;
                was_halted = m_halted;
                rd_val     = m_read(req_offset[3:2]);
                pop_now    = (m_q.size() != 0) && tx_ready;
                push_now   = req_valid && req_we && (req_offset[3:2] == 2'd0) && m_ready();
                m_resp_valid = req_valid && !req_we;
                if (req_valid && !req_we) m_resp_rdata = rd_val;
                if (pop_now)  void'(m_q.pop_front());
                if (push_now) m_q.push_back(req_wdata[7:0]);
                if (req_valid && req_we && (req_offset[3:2] == 2'd2) && !m_halted) begin
                    m_halted = 1'b1;
                    m_exit   = req_wdata;
                end
                if (!was_halted) m_cycle = m_cycle + 1;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("tx_valid", 64'(tx_valid), 64'(m_q.size() != 0));
                if (m_q.size() != 0) check("tx_data", 64'(tx_data), 64'(m_q[0]));
                check("req_ready", 64'(req_ready), 64'(m_ready()));
                check("halted", 64'(halted), 64'(m_halted));
                check("exit_code", 64'(exit_code), 64'(m_exit));
                check("resp_valid", 64'(resp_valid), 64'(m_resp_valid));
                check("resp_rdata", 64'(resp_rdata), 64'(m_resp_rdata));
                if (tx_valid && tx_ready) drained.push_back(tx_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] off, input logic [31:0] data);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_offset = off;
        req_wdata  = data;
        do begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 40);
        req_valid = 1'b0;
        req_we    = 1'b0;
        if (!acc) check("bus_write accept timeout", 64'(0), 64'(1));
    endtask

    task automatic bus_read(input logic [3:0] off, output logic [31:0] data);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_offset = off;
        tick();
        req_valid = 1'b0;
        check("read resp_valid", 64'(resp_valid), 64'(1));
        data = resp_rdata;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] c1;
        logic [31:0] c2;

        // Reset
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk_en = 1'b1;
        check("reset tx_valid", 64'(tx_valid), 64'(0));
        check("reset halted", 64'(halted), 64'(0));
        check("reset exit_code", 64'(exit_code), 64'(0));
        check("reset resp_valid", 64'(resp_valid), 64'(0));
        bus_read(4'h4, d);
        check("status after reset", 64'(d), 64'(32'h0000_0002));
        repeat (9) tick();
        bus_read(4'hC, d);
        check("cycle at 10 within 9..11", 64'(d >= 9 && d <= 11), 64'(1));

        // Two bytes straight through
        drained.delete();
        tx_ready = 1'b1;
        bus_write(4'h0, 32'h48);
        bus_write(4'h0, 32'h69);
        repeat (3) tick();
        check("hi count", 64'(drained.size()), 64'(2));
        check("hi byte0", 64'(dq(0)), 64'(8'h48));
        check("hi byte1", 64'(dq(1)), 64'(8'h69));
        bus_read(4'h4, d);
        check("status empty after hi", 64'(d), 64'(32'h0000_0002));

        // Fill, back-pressure, pop-unblocked push, drain across wrap
        drained.delete();
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) bus_write(4'h0, 32'h10 + 32'(i));
        bus_read(4'h4, d);
        check("status full", 64'(d), 64'(32'h0000_1001));
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_offset = 4'h0;
        req_wdata  = 32'h20;
        @(negedge clk);
        check("ready low when full", 64'(req_ready), 64'(0));
        tick();
        @(negedge clk);
        check("ready still low", 64'(req_ready), 64'(0));
        tick();
        tx_ready = 1'b1;
        @(negedge clk);
        check("ready high with pop", 64'(req_ready), 64'(1));
        tick();
        req_valid = 1'b0;
        req_we    = 1'b0;
        tx_ready  = 1'b0;
        bus_read(4'h4, d);
        check("status full after swap", 64'(d), 64'(32'h0000_1001));
        tx_ready = 1'b1;
        repeat (17) tick();
        tx_ready = 1'b0;
        check("wrap drain count", 64'(drained.size()), 64'(17));
        for (int i = 0; i < 17; i++) check("wrap drain order", 64'(dq(i)), 64'(8'h10 + 8'(i)));
        bus_read(4'h4, d);
        check("status empty after wrap", 64'(d), 64'(32'h0000_0002));

        // Simultaneous push and pop at count 3
        drained.delete();
        bus_write(4'h0, 32'hA1);
        bus_write(4'h0, 32'hA2);
        bus_write(4'h0, 32'hA3);
        tx_ready = 1'b1;
        bus_write(4'h0, 32'hA4);
        tx_ready = 1'b0;
        bus_read(4'h4, d);
        check("status count 3", 64'(d), 64'(32'h0000_0300));
        check("head advanced", 64'(tx_data), 64'(8'hA2));
        tx_ready = 1'b1;
        repeat (4) tick();
        tx_ready = 1'b0;
        check("pp drain count", 64'(drained.size()), 64'(4));
        check("pp byte0", 64'(dq(0)), 64'(8'hA1));
        check("pp byte3", 64'(dq(3)), 64'(8'hA4));

        // EXIT is sticky; cycle freezes; output still drains
        bus_write(4'h8, 32'h0000_002A);
        check("halted after exit", 64'(halted), 64'(1));
        check("exit_code first", 64'(exit_code), 64'(32'h2A));
        bus_write(4'hB, 32'h0000_0001);
        bus_read(4'h8, d);
        check("exit read sticky", 64'(d), 64'(32'h2A));
        check("exit_code sticky", 64'(exit_code), 64'(32'h2A));
        bus_read(4'hC, c1);
        repeat (4) tick();
        bus_read(4'hD, c2);
        check("cycle frozen", 64'(c2), 64'(c1));
        drained.delete();
        tx_ready = 1'b1;
        bus_write(4'h0, 32'h0A);
        repeat (2) tick();
        tx_ready = 1'b0;
        check("post-halt drain count", 64'(drained.size()), 64'(1));
        check("post-halt byte", 64'(dq(0)), 64'(8'h0A));
        bus_read(4'h4, d);
        check("status halted empty", 64'(d), 64'(32'h0000_0006));

        // Asynchronous reset mid-drain
        for (int i = 0; i < 5; i++) bus_write(4'h0, 32'h31 + 32'(i));
        bus_read(4'h4, d);
        check("status count 5 halted", 64'(d), 64'(32'h0000_0504));
        tx_ready = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("async rst tx_valid", 64'(tx_valid), 64'(0));
        check("async rst halted", 64'(halted), 64'(0));
        check("async rst exit_code", 64'(exit_code), 64'(0));
        check("async rst resp_valid", 64'(resp_valid), 64'(0));
        tx_ready = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        bus_read(4'h4, d);
        check("status after async rst", 64'(d), 64'(32'h0000_0002));
        bus_read(4'h8, d);
        check("exit after async rst", 64'(d), 64'(0));

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
